// File: rtl/uart_cmd_responder_pkg.sv
// Shared types and protocol constants for the UART command responder.
package uart_cmd_responder_pkg;
`include "uart_proto.vh"

  localparam logic [7:0] CMD_WRITE = `UART_CMD_WRITE;
  localparam logic [7:0] CMD_READ  = `UART_CMD_READ;
  localparam logic [7:0] ACK_BYTE  = `UART_ACK;
  localparam logic [7:0] NAK_BYTE  = `UART_NAK;

  typedef enum logic [2:0] {
    IDLE, ADDR_HI, ADDR_LO, DATA, BUS, TX_SEND, TX_WAIT
  } state_t;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction
endpackage

// File: rtl/cycle_timer.sv
// Up-counter timeout: cleared by load, advances while enabled, flags when the
// count reaches limit. Used for both the inter-byte and bus-ack timeouts.
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);
  logic [W-1:0] count;

  // Count cycles since the last load; load has priority over enable.
  always_ff @(posedge clk) begin
    if (rst)         count <= '0;
    else if (load)   count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  // A load in the same cycle (fresh byte) always beats expiry.
  assign expired = enable && !load && (count == limit);
endmodule

// File: rtl/uart_proto.vh
// Byte codes of the UART command protocol. Plain defines so host-side tools
// can pick up the same values.
`ifndef UART_PROTO_VH
`define UART_PROTO_VH

`define UART_CMD_WRITE 8'h57
`define UART_CMD_READ  8'h52
`define UART_ACK       8'h06
`define UART_NAK       8'h15

`endif

// File: rtl/uart_cmd_responder.sv
// Decodes write/read packets from a UART byte stream, runs one bus cycle per
// packet and sends back a single reply byte (ACK, read data or NAK).
module uart_cmd_responder
  import uart_cmd_responder_pkg::*;
#(
  parameter logic [15:0] RX_TIMEOUT  = 16'd65535,
  parameter logic [7:0]  BUS_TIMEOUT = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  RXbuffer_i,
  input  logic        RXready_i,
  output logic [7:0]  TXbuffer_o,
  output logic        TXstart_o,
  input  logic        TXbusy_i,
  output logic [15:0] addr_o,
  output logic [7:0]  wdata_o,
  output logic        we_o,
  output logic        stb_o,
  input  logic        ack_i,
  input  logic [7:0]  rdata_i
);
  state_t      state;
  logic        first_wait;
  logic        collecting;
  logic        t_load;
  logic        t_en;
  logic        t_exp;
  logic [15:0] t_limit;

  assign collecting = (state == ADDR_HI) || (state == ADDR_LO) || (state == DATA);
  // Timer is held cleared in IDLE and reloaded on every accepted packet byte,
  // so it starts from zero both on packet start and on BUS entry.
  assign t_load     = (state == IDLE) || (collecting && RXready_i);
  assign t_en       = collecting || (state == BUS);
  assign t_limit    = (state == BUS) ? {8'h00, BUS_TIMEOUT} : RX_TIMEOUT;

  cycle_timer #(.W(16)) u_timer (
    .clk     (clk_i),
    .rst     (rst_i),
    .load    (t_load),
    .enable  (t_en),
    .limit   (t_limit),
    .expired (t_exp)
  );

  // Packet FSM with registered bus and transmitter outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      first_wait <= 1'b0;
      TXstart_o  <= 1'b0;
      TXbuffer_o <= 8'h00;
      stb_o      <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= 16'h0000;
      wdata_o    <= 8'h00;
    end else begin
      TXstart_o <= 1'b0;
      case (state)
        IDLE: if (RXready_i) begin
          if (is_cmd(RXbuffer_i)) begin
            we_o  <= (RXbuffer_i == CMD_WRITE);
            state <= ADDR_HI;
          end else begin
            TXbuffer_o <= NAK_BYTE;
            state      <= TX_SEND;
          end
        end
        ADDR_HI: if (RXready_i) begin
          addr_o[15:8] <= RXbuffer_i;
          state        <= ADDR_LO;
        end else if (t_exp) state <= IDLE;
        ADDR_LO: if (RXready_i) begin
          addr_o[7:0] <= RXbuffer_i;
          if (we_o) state <= DATA;
          else begin
            stb_o <= 1'b1;
            state <= BUS;
          end
        end else if (t_exp) state <= IDLE;
        DATA: if (RXready_i) begin
          wdata_o <= RXbuffer_i;
          stb_o   <= 1'b1;
          state   <= BUS;
        end else if (t_exp) state <= IDLE;
        // Bytes arriving from here until IDLE are deliberately dropped.
        BUS: if (ack_i) begin
          stb_o      <= 1'b0;
          TXbuffer_o <= we_o ? ACK_BYTE : rdata_i;
          state      <= TX_SEND;
        end else if (t_exp) begin
          stb_o      <= 1'b0;
          TXbuffer_o <= NAK_BYTE;
          state      <= TX_SEND;
        end
        TX_SEND: if (!TXbusy_i) begin
          TXstart_o  <= 1'b1;
          first_wait <= 1'b1;
          state      <= TX_WAIT;
        end
        // Transmitter may not raise busy until after it sees the start pulse.
        TX_WAIT: if (first_wait) first_wait <= 1'b0;
                 else if (!TXbusy_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_cmd_responder.md
UART_CMD_RESPONDER -- requirements
Module: uart_cmd_responder

Interface
REQ-001 SHALL have parameter RX_TIMEOUT, default 16'd65535; idle cycles allowed between bytes of one packet.
REQ-002 SHALL have parameter BUS_TIMEOUT, default 8'd255; cycles allowed for ack_i.
REQ-003 SHALL have port clk_i  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port RXbuffer_i  input  8  byte from the UART receiver.
REQ-006 SHALL have port RXready_i  input  1  one-cycle strobe, RXbuffer_i valid.
REQ-007 SHALL have port TXbuffer_o  output  8  byte to the UART transmitter.
REQ-008 SHALL have port TXstart_o  output  1  one-cycle transmit request.
REQ-009 SHALL have port TXbusy_i  input  1  transmitter busy.
REQ-010 SHALL have port addr_o  output  16  bus address.
REQ-011 SHALL have port wdata_o  output  8  bus write data.
REQ-012 SHALL have port we_o  output  1  1 = write cycle, 0 = read cycle.
REQ-013 SHALL have port stb_o  output  1  bus request, held until ack_i or timeout.
REQ-014 SHALL have port ack_i  input  1  bus completion; rdata_i valid when ack_i=1.
REQ-015 SHALL have port rdata_i  input  8  bus read data.

Function
REQ-016 SHALL decode packets: write = 0x57, addr_hi, addr_lo, data; read = 0x52, addr_hi, addr_lo.
REQ-017 SHALL use states IDLE, ADDR_HI, ADDR_LO, DATA, BUS, TX_SEND, TX_WAIT.
REQ-018 SHALL, in IDLE on RXready_i: 0x57/0x52 -> ADDR_HI, latch the command; any other byte -> TX_SEND with NAK 0x15.
REQ-019 SHALL advance ADDR_HI -> ADDR_LO -> (write ? DATA : BUS) and DATA -> BUS, each on RXready_i, latching the byte.
REQ-020 SHALL assert stb_o from the first cycle in BUS; drive addr_o/wdata_o/we_o stable while stb_o=1.
REQ-021 SHALL, on ack_i in BUS, deassert stb_o in the next cycle and go to TX_SEND with reply byte ACK 0x06 (write) or rdata_i captured that cycle (read).
REQ-022 SHALL, if ack_i is absent for BUS_TIMEOUT+1 cycles in BUS, drop stb_o and go to TX_SEND with NAK 0x15.
REQ-023 SHALL, in TX_SEND with TXbusy_i=0, pulse TXstart_o for exactly one cycle with TXbuffer_o valid, then go to TX_WAIT; if TXbusy_i=1, stay in TX_SEND.
REQ-024 SHALL ignore TXbusy_i in the first TX_WAIT cycle, then return to IDLE on the first cycle with TXbusy_i=0.
REQ-025 SHALL, in ADDR_HI/ADDR_LO/DATA, return to IDLE with no reply after RX_TIMEOUT+1 cycles without RXready_i; counter reloads on each byte.
REQ-026 SHALL drop RXready_i strobes that arrive in BUS, TX_SEND or TX_WAIT; these bytes are lost.
REQ-027 SHALL hold TXbuffer_o constant from entry to TX_SEND until return to IDLE.
REQ-028 SHALL produce exactly one reply byte per completed or rejected packet and none per timed-out packet.

Reset
REQ-029 SHALL, on rst_i=1 at posedge, force state IDLE, TXstart_o=0, stb_o=0, we_o=0, addr_o=0, wdata_o=0, TXbuffer_o=0, counters 0, even mid-packet or mid-bus-cycle.
REQ-030 SHALL NOT wait for ack_i or TXbusy_i to clear before accepting a new packet after reset.

Structure
REQ-031 SHALL take command codes 0x57/0x52, ACK 0x06 and NAK 0x15 from a shared include, uart_proto.vh, also used by host tools.
REQ-032 SHALL use one sub-module, cycle_timer (load, enable, expired), shared by the RX and bus timeouts.

Verification
REQ-033 SHALL cover 57 12 34 A5 with ack_i after 3 cycles -> one stb_o cycle group: addr 0x1234, wdata 0xA5, we_o=1; then TX byte 0x06.
REQ-034 SHALL cover 52 00 FF with rdata_i=0x3C at ack -> we_o=0, addr 0x00FF; TX byte 0x3C.
REQ-035 SHALL cover byte 0x41 in IDLE -> TX byte 0x15; no stb_o.
REQ-036 SHALL cover 57 12 then silence (RX_TIMEOUT=16) -> IDLE after 17 cycles; no TX; following 52 00 01 serviced normally.
REQ-037 SHALL cover read with ack_i never asserted (BUS_TIMEOUT=8) -> stb_o drops after 9 cycles; TX byte 0x15.
REQ-038 SHALL cover rst_i pulse during BUS with stb_o=1 -> stb_o=0 next cycle; state IDLE; no TXstart_o.
